// File: rtl/asm_data_path_param_pkg.sv
// Shared opcodes and flag indices for the ASM data path.
// Imported by the top and the testbench.
package asm_dp_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_LOAD = 3'd0;
  localparam logic [OPW-1:0] OP_ADD  = 3'd1;
  localparam logic [OPW-1:0] OP_SUB  = 3'd2;
  localparam logic [OPW-1:0] OP_AND  = 3'd3;
  localparam logic [OPW-1:0] OP_OR   = 3'd4;
  localparam logic [OPW-1:0] OP_XOR  = 3'd5;
  localparam logic [OPW-1:0] OP_MOV  = 3'd6;
  localparam logic [OPW-1:0] OP_MUL  = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int NFLAGS = 3;

endpackage

// File: rtl/asm_data_path_param_if.sv
// Command channel from the ASM controller to the data path.
// master: controller side (valid, op, indices, in_data); slave: data path.
interface asm_data_path_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 2
);
  import asm_dp_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_op;
  logic [AW-1:0]    cmd_dst;
  logic [AW-1:0]    cmd_src_a;
  logic [AW-1:0]    cmd_src_b;
  logic [WIDTH-1:0] in_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst,
    output cmd_src_a, cmd_src_b, in_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst,
    input  cmd_src_a, cmd_src_b, in_data,
    output cmd_ready
  );

endinterface

// File: rtl/asm_data_path_param_mul.sv
// Iterative shift-add multiplier, WIDTH iterations after start.
// Ports: start/a/b in; busy, result_valid (final iteration), result out.
module asm_dp_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] addend;

  // result is the accumulator after the current iteration, so the
  // final product is available combinationally on the last edge.
  assign addend       = mplier[0] ? mcand : '0;
  assign result       = acc + addend;
  assign result_valid = busy && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/asm_data_path_param.sv
// Parametrised ASM data path: register file, ALU, iterative MUL.
// Ports: clk, rst, cmd (slave), rd_addr/rd_data, busy, done, flags.
module asm_data_path_param
  import asm_dp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 4,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  asm_data_path_param_if.slave cmd,
  input  logic [AW-1:0]        rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_c
);

  logic [WIDTH-1:0]  regs [NREGS];
  logic [NFLAGS-1:0] flags;
  logic [AW-1:0]     mul_dst;

  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_rv;
  logic [WIDTH-1:0] mul_res;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  logic             wr_fire;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_val;
  logic             wr_c;
  logic             wr_ok;

  // Indices past NREGS read as zero.
  function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] i);
    return (int'(i) < NREGS) ? regs[i] : '0;
  endfunction

  assign accept        = cmd.cmd_valid && !mul_busy;
  assign mul_start     = accept && (cmd.cmd_op == OP_MUL);
  assign cmd.cmd_ready = !mul_busy;
  assign busy          = mul_busy;
  assign rd_data       = rd(rd_addr);
  assign flag_z        = flags[FLAG_Z];
  assign flag_n        = flags[FLAG_N];
  assign flag_c        = flags[FLAG_C];

  assign opa = rd(cmd.cmd_src_a);
  assign opb = rd(cmd.cmd_src_b);

  asm_dp_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .a            (opa),
    .b            (opb),
    .busy         (mul_busy),
    .result_valid (mul_rv),
    .result       (mul_res)
  );

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (cmd.cmd_op)
      OP_LOAD: alu_res = cmd.in_data;
      OP_ADD:  {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
      OP_SUB: begin
        alu_res = opa - opb;
        alu_c   = opa < opb;
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_MOV:  alu_res = opa;
      OP_MUL:  alu_res = '0;
    endcase
  end

  // A MUL completion and a new command never coincide: accept needs !busy.
  always_comb begin
    wr_fire = (accept && (cmd.cmd_op != OP_MUL)) || mul_rv;
    wr_idx  = mul_rv ? mul_dst : cmd.cmd_dst;
    wr_val  = mul_rv ? mul_res : alu_res;
    wr_c    = mul_rv ? 1'b0 : alu_c;
    wr_ok   = int'(wr_idx) < NREGS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags   <= '0;
      done    <= 1'b0;
      mul_dst <= '0;
    end else begin
      done <= wr_fire;
      if (mul_start) mul_dst <= cmd.cmd_dst;
      if (wr_fire && wr_ok) begin
        regs[wr_idx]  <= wr_val;
        flags[FLAG_Z] <= (wr_val == '0);
        flags[FLAG_N] <= wr_val[WIDTH-1];
        flags[FLAG_C] <= wr_c;
      end
    end
  end

endmodule
